// File: rtl/autosa_sdp_core_unpack_if.sv
// Beat-in / word-out stream bundle for the SDP unpack stage.
// slave = the unpack core, master = the producer/consumer side.
interface autosa_sdp_core_unpack_if #(
    parameter int IW    = 512,
    parameter int OW    = 128,
    parameter int RATIO = IW / OW
);
    logic             inp_pvld;
    logic             inp_prdy;
    logic [OW-1:0]    inp_data;
    logic             inp_last;
    logic             out_pvld;
    logic             out_prdy;
    logic [IW-1:0]    out_data;
    logic [RATIO-1:0] out_mask;

    modport master (
        output inp_pvld, inp_data, inp_last, out_prdy,
        input  inp_prdy, out_pvld, out_data, out_mask
    );

    modport slave (
        input  inp_pvld, inp_data, inp_last, out_prdy,
        output inp_prdy, out_pvld, out_data, out_mask
    );
endinterface

// File: rtl/autosa_sdp_core_unpack.sv
// Gathers RATIO narrow beats (segment 0 first, LSB) into one wide word with a
// per-segment fill mask; inp_last closes a word early, unfilled segments read zero.
module autosa_sdp_core_unpack #(
    parameter int IW    = 512,
    parameter int OW    = 128,
    parameter int RATIO = IW / OW
) (
    input  logic                         autosa_core_clk,
    input  logic                         autosa_core_rst,
    autosa_sdp_core_unpack_if.slave      bus
);

    localparam logic [3:0] LAST_SEG = 4'(RATIO - 1);

    logic [3:0]       seg_cnt;
    logic [IW-1:0]    acc_data;
    logic [RATIO-1:0] acc_mask;
    logic [IW-1:0]    beat_data;
    logic [RATIO-1:0] beat_mask;
    logic             out_pvld_q;
    logic [IW-1:0]    out_data_q;
    logic [RATIO-1:0] out_mask_q;
    logic             inp_prdy;
    logic             inp_acc;
    logic             out_acc;
    logic             word_done;

    always_comb begin
        inp_prdy  = !out_pvld_q || bus.out_prdy;
        inp_acc   = bus.inp_pvld && inp_prdy;
        out_acc   = out_pvld_q && bus.out_prdy;
        word_done = inp_acc && ((seg_cnt == LAST_SEG) || bus.inp_last);
    end

    // Place the incoming beat into its segment slot; all other slots stay zero.
    always_comb begin
        beat_data = '0;
        beat_mask = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (seg_cnt == 4'(i)) begin
                beat_data[i*OW +: OW] = bus.inp_data;
                beat_mask[i]          = 1'b1;
            end
        end
    end

    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            seg_cnt    <= '0;
            acc_data   <= '0;
            acc_mask   <= '0;
            out_pvld_q <= 1'b0;
            out_data_q <= '0;
            out_mask_q <= '0;
        end else begin
            // Drain first; a completing beat in the same cycle overrides it.
            if (out_acc) begin
                out_pvld_q <= 1'b0;
            end
            if (inp_acc) begin
                if (word_done) begin
                    out_pvld_q <= 1'b1;
                    out_data_q <= acc_data | beat_data;
                    out_mask_q <= acc_mask | beat_mask;
                    seg_cnt    <= '0;
                    acc_data   <= '0;
                    acc_mask   <= '0;
                end else begin
                    seg_cnt    <= seg_cnt + 4'd1;
                    acc_data   <= acc_data | beat_data;
                    acc_mask   <= acc_mask | beat_mask;
                end
            end
        end
    end

    assign bus.inp_prdy = inp_prdy;
    assign bus.out_pvld = out_pvld_q;
    assign bus.out_data = out_data_q;
    assign bus.out_mask = out_mask_q;

endmodule

// File: doc/autosa_sdp_core_unpack.md
AUTOSA_SDP_CORE_UNPACK -- requirements
Module: autosa_sdp_core_unpack

Interface
REQ-001 SHALL provide parameter IW, default 512, output word width in bits.
REQ-002 SHALL provide parameter OW, default 128, input beat width in bits.
REQ-003 SHALL provide parameter RATIO, default IW/OW, beats per word; legal values 1, 2, 4, 8, 16.
REQ-004 autosa_core_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 autosa_core_rst  input  1  reset, synchronous, active-high.
REQ-006 inp_pvld  input  1  input beat valid.
REQ-007 inp_prdy  output  1  input beat ready.
REQ-008 inp_data  input  OW  input beat payload.
REQ-009 inp_last  input  1  beat closes the current word early; qualified by inp_pvld.
REQ-010 out_pvld  output  1  output word valid, registered.
REQ-011 out_prdy  input  1  output word ready.
REQ-012 out_data  output  IW  assembled word, registered.
REQ-013 out_mask  output  RATIO  per-segment filled flags, registered.

Function
REQ-014 Input accept (inp_acc) SHALL be inp_pvld & inp_prdy; output accept (out_acc) SHALL be out_pvld & out_prdy.
REQ-015 inp_prdy SHALL be (!out_pvld) | out_prdy, combinational, independent of inp_pvld, inp_last and inp_data.
REQ-016 seg_cnt (4 bits) SHALL select the target segment; an accepted beat SHALL be written to accumulator bits [OW*seg_cnt+OW-1 : OW*seg_cnt], with its mask bit set.
REQ-017 A beat SHALL complete the word when it is accepted with seg_cnt==RATIO-1 or inp_last==1.
REQ-018 Non-completing accepted beat: seg_cnt increments by 1; out_* unchanged except through REQ-021.
REQ-019 Completing accepted beat: next cycle out_pvld=1; out_data = accumulator merged with the current beat; out_mask = accumulated mask merged with the current bit; unfilled segments SHALL be zero in out_data and zero in out_mask.
REQ-020 On a completing beat, seg_cnt, the accumulator and the accumulated mask SHALL clear to 0 in the same cycle.
REQ-021 out_acc with no completing beat in the same cycle: out_pvld SHALL go to 0 next cycle; out_data and out_mask SHALL hold their values.
REQ-022 out_acc and a completing beat in the same cycle: out_pvld SHALL stay 1 and out_data/out_mask SHALL load the new word; no bubble and no loss.
REQ-023 While out_pvld=1 and out_prdy=0: out_data, out_mask and out_pvld SHALL be stable, and inp_prdy=0.
REQ-024 Latency SHALL be 1 cycle from the completing input beat to out_pvld. Sustained throughput SHALL be 1 beat per cycle when out_prdy=1.
REQ-025 Segment order SHALL be first beat in segment 0, least-significant, matching the downstream pack stage.
REQ-026 RATIO==1: every accepted beat SHALL complete a word, with out_mask=1'b1; inp_last has no additional effect.
REQ-027 inp_last on the first beat (seg_cnt==0) SHALL emit a word with only segment 0 filled.
REQ-028 seg_cnt SHALL never exceed RATIO-1; wrap occurs only through REQ-020.

Reset
REQ-029 While autosa_core_rst=1 at a clock edge: out_pvld=0, out_data=0, out_mask=0, seg_cnt=0, accumulator=0 and accumulated mask=0 next cycle.
REQ-030 Reset mid-word SHALL discard the partial word without emitting it; reset SHALL also discard a pending output word.
REQ-031 inp_prdy SHALL be 1 in the first cycle after reset is released.

Verification (IW=512, OW=128, RATIO=4)
REQ-032 Scenario: 4 beats A0..A3 on consecutive cycles with out_prdy=1 -> one cycle after A3, out_pvld=1, out_data={A3,A2,A1,A0}, out_mask=4'b1111.
REQ-033 Scenario: beats B0, B1 with inp_last=1 on B1 -> out_data={256'h0,B1,B0}, out_mask=4'b0011; the next beat lands in segment 0.
REQ-034 Scenario: word pending with out_prdy=0 for 5 cycles -> out_data/out_mask stable and inp_prdy=0 throughout; out_prdy=1 -> word accepted and inp_prdy=1.
REQ-035 Scenario: 8 back-to-back beats with out_prdy=1 -> 2 words, with out_pvld continuously 1 across the word boundary where applicable and no dropped beat.
REQ-036 Scenario: 2 beats accepted, then autosa_core_rst=1 for 1 cycle, then 4 new beats -> only the new 4-beat word emitted, with mask 4'b1111.
REQ-037 Scenario: RATIO=1, OW=IW=128, beat C -> out_data=C, out_mask=1'b1 one cycle later.
